// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall sequencer: RAW Tuse/Tnew stalls plus mult/div busy tracking.
// In: Clk, Reset (async low), D/E/M hazard info, E_MD_Start/Div; out: stall set, MD_Busy, Stall_Cnt.
module pipe_stall_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [4:0]  D_Rs,
   input  logic [4:0]  D_Rt,
   input  logic [1:0]  D_Tuse_Rs,
   input  logic [1:0]  D_Tuse_Rt,
   input  logic        D_Is_MD,
   input  logic [4:0]  E_Rd,
   input  logic [1:0]  E_Tnew,
   input  logic [4:0]  M_Rd,
   input  logic [1:0]  M_Tnew,
   input  logic        E_MD_Start,
   input  logic        E_MD_Div,
   output logic        Stall,
   output logic        FD_Hold,
   output logic        PC_En,
   output logic        DE_Clear,
   output logic        MD_Busy,
   output logic [31:0] Stall_Cnt
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_stall_cnt;

   logic w_hz_rs;
   logic w_hz_rt;
   logic w_md_stall;
   logic w_stall;

   assign w_hz_rs = (D_Rs != 5'd0) &&
      (((E_Rd == D_Rs) && (E_Tnew > D_Tuse_Rs)) ||
       ((M_Rd == D_Rs) && (M_Tnew > D_Tuse_Rs)));

   assign w_hz_rt = (D_Rt != 5'd0) &&
      (((E_Rd == D_Rt) && (E_Tnew > D_Tuse_Rt)) ||
       ((M_Rd == D_Rt) && (M_Tnew > D_Tuse_Rt)));

   assign w_md_stall = D_Is_MD && (E_MD_Start || MD_Busy);

   // Gated by Reset so the pipeline runs freely while held in reset.
   assign w_stall = Reset && (w_hz_rs || w_hz_rt || w_md_stall);

   assign Stall     = w_stall;
   assign FD_Hold   = w_stall;
   assign PC_En     = ~w_stall;
   assign DE_Clear  = w_stall;
   assign MD_Busy   = (r_state == S_BUSY);
   assign Stall_Cnt = r_stall_cnt;

   // A start arriving while busy is dropped; a stalled pipe never issues one.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (E_MD_Start) begin
                  r_state <= S_BUSY;
                  r_cnt   <= E_MD_Div ? DIV_CNT : MULT_CNT;
               end
            end
            S_BUSY: begin
               if (r_cnt == 4'd1) begin
                  r_state <= S_IDLE;
                  r_cnt   <= 4'd0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_stall_cnt <= 32'd0;
      end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with a scoreboard queue.
// Each step pushes expected outputs, samples mid-cycle, pops and asserts.
module tb_pipe_stall_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [4:0]  D_Rs, D_Rt, E_Rd, M_Rd;
   logic [1:0]  D_Tuse_Rs, D_Tuse_Rt, E_Tnew, M_Tnew;
   logic        D_Is_MD, E_MD_Start, E_MD_Div;
   logic        Stall, FD_Hold, PC_En, DE_Clear, MD_Busy;
   logic [31:0] Stall_Cnt;

   typedef struct {
      string       tag;
      logic [4:0]  vec;
      logic [31:0] cnt;
   } sb_t;

   sb_t         q[$];
   int          passed = 0;
   int          total  = 0;
   logic [31:0] cnt_m  = 32'd0;

   pipe_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .Clk(Clk), .Reset(Reset),
      .D_Rs(D_Rs), .D_Rt(D_Rt),
      .D_Tuse_Rs(D_Tuse_Rs), .D_Tuse_Rt(D_Tuse_Rt),
      .D_Is_MD(D_Is_MD),
      .E_Rd(E_Rd), .E_Tnew(E_Tnew),
      .M_Rd(M_Rd), .M_Tnew(M_Tnew),
      .E_MD_Start(E_MD_Start), .E_MD_Div(E_MD_Div),
      .Stall(Stall), .FD_Hold(FD_Hold), .PC_En(PC_En),
      .DE_Clear(DE_Clear), .MD_Busy(MD_Busy),
      .Stall_Cnt(Stall_Cnt)
   );

   always #5 Clk = ~Clk;

   // Called just after a negedge; samples 2ns later, then moves to next negedge.
   task automatic step(input string tag, input bit es, input bit eb);
      sb_t e, o;
      logic [4:0] obs;
      e.tag = tag;
      e.vec = {es, es, ~es, es, eb};
      e.cnt = cnt_m;
      q.push_back(e);
      #2;
      o = q.pop_front();
      obs = {Stall, FD_Hold, PC_En, DE_Clear, MD_Busy};
      total++;
      assert (obs === o.vec) passed++;
      else $error("FAIL %s outs obs=%b exp=%b", o.tag, obs, o.vec);
      total++;
      assert (Stall_Cnt === o.cnt) passed++;
      else $error("FAIL %s_cnt obs=%h exp=%h", o.tag, Stall_Cnt, o.cnt);
      if (es && Reset && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
      @(negedge Clk);
   endtask

   task automatic clr_hz();
      D_Rs = 5'd0; D_Rt = 5'd0; E_Rd = 5'd0; M_Rd = 5'd0;
      D_Tuse_Rs = 2'd3; D_Tuse_Rt = 2'd3;
      E_Tnew = 2'd0; M_Tnew = 2'd0;
      D_Is_MD = 1'b0; E_MD_Start = 1'b0; E_MD_Div = 1'b0;
   endtask

   task automatic rst_pulse();
      Reset = 1'b0;
      #1;
      Reset = 1'b1;
      cnt_m = 32'd0;
   endtask

   initial begin
      Reset = 1'b0;
      clr_hz();
      E_Rd = 5'd8; E_Tnew = 2'd2; D_Rs = 5'd8; D_Tuse_Rs = 2'd1;
      D_Is_MD = 1'b1; E_MD_Start = 1'b1;
      #1;
      step("in_reset", 1'b0, 1'b0);
      step("in_reset2", 1'b0, 1'b0);
      Reset = 1'b1;
      clr_hz();
      step("idle", 1'b0, 1'b0);

      E_Rd = 5'd8; E_Tnew = 2'd2; D_Rs = 5'd8; D_Tuse_Rs = 2'd1;
      step("raw_e_rs", 1'b1, 1'b0);
      D_Rs = 5'd0;
      step("rs_zero", 1'b0, 1'b0);
      D_Rs = 5'd8; E_Tnew = 2'd1;
      step("tnew_eq_tuse", 1'b0, 1'b0);
      clr_hz();
      M_Rd = 5'd9; M_Tnew = 2'd2; D_Rt = 5'd9; D_Tuse_Rt = 2'd0;
      step("raw_m_rt", 1'b1, 1'b0);
      D_Tuse_Rt = 2'd3;
      step("rt_unused", 1'b0, 1'b0);
      D_Tuse_Rt = 2'd1; M_Tnew = 2'd1;
      step("m_tnew_eq", 1'b0, 1'b0);
      M_Rd = 5'd7; M_Tnew = 2'd2;
      step("m_rd_diff", 1'b0, 1'b0);

      clr_hz();
      rst_pulse();
      D_Is_MD = 1'b1; E_MD_Start = 1'b1; E_MD_Div = 1'b0;
      step("mul_t", 1'b1, 1'b0);
      E_MD_Start = 1'b0;
      for (int i = 1; i <= 5; i++) step("mul_busy", 1'b1, 1'b1);
      step("mul_done", 1'b0, 1'b0);
      total++;
      assert (Stall_Cnt === 32'd6) passed++;
      else $error("FAIL mul_stall_cnt obs=%h exp=%h", Stall_Cnt, 32'd6);

      D_Is_MD = 1'b0; E_MD_Start = 1'b1; E_MD_Div = 1'b1;
      step("div_t", 1'b0, 1'b0);
      E_MD_Start = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         E_MD_Start = (i == 3);
         E_MD_Div = 1'b0;
         step("div_busy", 1'b0, 1'b1);
      end
      step("div_done", 1'b0, 1'b0);

      D_Is_MD = 1'b1; E_MD_Start = 1'b1; E_MD_Div = 1'b1;
      step("div2_t", 1'b1, 1'b0);
      E_MD_Start = 1'b0;
      step("div2_t1", 1'b1, 1'b1);
      step("div2_t2", 1'b1, 1'b1);
      Reset = 1'b0;
      cnt_m = 32'd0;
      step("rst_mid", 1'b0, 1'b0);
      Reset = 1'b1;
      D_Is_MD = 1'b0; E_MD_Start = 1'b1; E_MD_Div = 1'b0;
      step("mul2_t", 1'b0, 1'b0);
      E_MD_Start = 1'b0;
      for (int i = 1; i <= 5; i++) step("mul2_busy", 1'b0, 1'b1);
      step("mul2_done", 1'b0, 1'b0);

      clr_hz();
      force dut.r_stall_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.r_stall_cnt;
      cnt_m = 32'hFFFF_FFFE;
      E_Rd = 5'd4; E_Tnew = 2'd3; D_Rt = 5'd4; D_Tuse_Rt = 2'd0;
      step("sat0", 1'b1, 1'b0);
      step("sat1", 1'b1, 1'b0);
      step("sat2", 1'b1, 1'b0);
      clr_hz();
      step("sat_hold", 1'b0, 1'b0);
      total++;
      assert (Stall_Cnt === 32'hFFFF_FFFF) passed++;
      else $error("FAIL sat_final obs=%h exp=%h", Stall_Cnt, 32'hFFFF_FFFF);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
